// File: rtl/spi_pkg.sv
// Shared definitions for the SPI echo design: opcodes, controller states, byte width.
package spi_pkg;
    localparam int WIDTH = 8;

    localparam logic [7:0] OP_ECHO  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] ACK      = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop CDC synchronizer with a registered rising-edge pulse.
// The pulse lands one edge after the synchronized level rises.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
        prev_d  = chain_q[STAGES-1];
        rise_d  = chain_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = rise_q;
endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command decoder for the SPI echo design: syncs rx_ready/cs, decodes opcodes,
// holds the scratch register and issues one tx_load per received byte.
module spi_cmd_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH       = spi_pkg::WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rx_byte,
    input  logic             rx_ready,
    input  logic             cs,
    input  logic             tx_busy,
    output logic [WIDTH-1:0] tx_byte,
    output logic             tx_load,
    output logic [WIDTH-1:0] reg_out,
    output logic             overrun
);
    logic rx_stb, rx_lvl_unused;
    logic cs_s, cs_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rx_sync (
        .clk(clk), .rst_n(rst_n), .din(rx_ready), .level(rx_lvl_unused), .rise(rx_stb)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(cs), .level(cs_s), .rise(cs_rise_unused)
    );

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        tx_byte_d = tx_byte_q;
        reg_d     = reg_q;
        ovr_d     = ovr_q;
        tx_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_stb) begin
                    state_d = ST_RESP;
                    ret_d   = ST_IDLE;
                    case (rx_byte)
                        WIDTH'(OP_WRITE): begin
                            tx_byte_d = WIDTH'(ACK);
                            ret_d     = ST_ARG;
                        end
                        WIDTH'(OP_READ): tx_byte_d = reg_q;
                        WIDTH'(OP_ECHO): tx_byte_d = rx_byte;
                        default:         tx_byte_d = rx_byte;
                    endcase
                end
            end
            ST_ARG: begin
                if (rx_stb) begin
                    reg_d     = rx_byte;
                    tx_byte_d = WIDTH'(ACK);
                    ret_d     = ST_IDLE;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                // A byte landing here has nowhere to go: flag it and drop it.
                if (rx_stb) ovr_d = 1'b1;
                if (!tx_busy && !cs_s) begin
                    tx_load = 1'b1;
                    state_d = ret_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Frame abort overrides everything, including a response about to load.
        if (cs_s) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            tx_byte_q <= '0;
            reg_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            tx_byte_q <= tx_byte_d;
            reg_q     <= reg_d;
            ovr_q     <= ovr_d;
        end
    end

    assign tx_byte = tx_byte_q;
    assign reg_out = reg_q;
    assign overrun = ovr_q;
endmodule
